// File: rtl/aes_sbox_pkg.sv
// Shared types and constants for the shared S-box arbiter.
package aes_sbox_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;
  typedef enum logic {OWN_KEY, OWN_ST} owner_e;
  localparam int KEY_BYTES = 4;
  localparam int ST_BYTES  = 16;
endpackage

// File: rtl/SBoxLookup.sv
// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module SBoxLookup (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_inv;

  // x^254 via exponent chain 1,3,7,...,127 then one squaring; 0 maps to 0
  always_comb begin
    w_inv = i_byte;
    for (int i = 0; i < 6; i++) w_inv = gmul(gmul(w_inv, w_inv), i_byte);
    w_inv  = gmul(w_inv, w_inv);
    o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/sbox_share_arbiter.sv
// Shares one byte-wide S-box between key expansion (4 bytes) and the round
// datapath (16 bytes), one byte per clock, with grant/done pulses per port.
module sbox_share_arbiter
  import aes_sbox_pkg::*;
#(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_req,
  input  logic [31:0]  key_word,
  output logic         key_grant,
  output logic         key_done,
  output logic [31:0]  key_result,
  input  logic         st_req,
  input  logic [127:0] st_data,
  output logic         st_grant,
  output logic         st_done,
  output logic [127:0] st_result,
  output logic         busy
);
  state_e       r_state, w_next;
  owner_e       r_owner, r_last, w_win;
  logic [3:0]   r_cnt, w_last_idx;
  logic [127:0] r_buf;
  logic         w_accept;
  logic [7:0]   w_sb_in, w_sb_out;

  assign w_last_idx = (r_owner == OWN_KEY) ? 4'(KEY_BYTES - 1) : 4'(ST_BYTES - 1);
  assign w_sb_in    = r_buf[{r_cnt, 3'b000} +: 8];
  assign busy       = (r_state == S_RUN);

  SBoxLookup u_sbox (.i_byte(w_sb_in), .o_byte(w_sb_out));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and arbitration; ties go to the port not served last when RR is on
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_win    = r_owner;
    case (r_state)
      S_IDLE: begin
        if (key_req || st_req) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
          if (key_req && st_req)
            w_win = (RR_ENABLE && r_last == OWN_KEY) ? OWN_ST : OWN_KEY;
          else
            w_win = key_req ? OWN_KEY : OWN_ST;
        end
      end
      S_RUN:   if (r_cnt == w_last_idx) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Work buffer, byte counter, result registers and handshake pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_owner    <= OWN_ST;
      r_last     <= OWN_ST;
      key_grant  <= 1'b0;
      st_grant   <= 1'b0;
      key_done   <= 1'b0;
      st_done    <= 1'b0;
      key_result <= '0;
      st_result  <= '0;
    end else begin
      key_grant <= w_accept && (w_win == OWN_KEY);
      st_grant  <= w_accept && (w_win == OWN_ST);
      key_done  <= 1'b0;
      st_done   <= 1'b0;
      if (w_accept) begin
        r_buf   <= (w_win == OWN_KEY) ? {96'b0, key_word} : st_data;
        r_owner <= w_win;
        r_cnt   <= '0;
      end
      if (r_state == S_RUN) begin
        r_buf[{r_cnt, 3'b000} +: 8] <= w_sb_out;
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == S_FIN) begin
        if (r_owner == OWN_KEY) begin
          key_result <= r_buf[31:0];
          key_done   <= 1'b1;
        end else begin
          st_result <= r_buf;
          st_done   <= 1'b1;
        end
        r_last <= r_owner;
      end
    end
  end
endmodule

// File: tb/tb_sbox_share_arbiter.sv
module tb_sbox_share_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_req = 1'b0, st_req = 1'b0;
  logic [31:0] key_word = '0;
  logic [127:0] st_data = '0;
  logic key_grant, key_done, st_grant, st_done, busy;
  logic [31:0] key_result;
  logic [127:0] st_result;
  // second instance with fixed key priority
  logic z_key_req = 1'b0, z_st_req = 1'b0;
  logic z_key_grant, z_key_done, z_st_grant, z_st_done, z_busy;
  logic [31:0] z_key_result;
  logic [127:0] z_st_result;

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] sbox_tab [256];
  logic [31:0] m_key;
  logic [127:0] m_st;
  bit m_last_st;

  always #5 clk = ~clk;

  sbox_share_arbiter #(.RR_ENABLE(1'b1)) dut (
    .clk(clk), .reset(reset), .key_req(key_req), .key_word(key_word),
    .key_grant(key_grant), .key_done(key_done), .key_result(key_result),
    .st_req(st_req), .st_data(st_data), .st_grant(st_grant), .st_done(st_done),
    .st_result(st_result), .busy(busy));

  sbox_share_arbiter #(.RR_ENABLE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .key_req(z_key_req), .key_word(key_word),
    .key_grant(z_key_grant), .key_done(z_key_done), .key_result(z_key_result),
    .st_req(z_st_req), .st_data(st_data), .st_grant(z_st_grant), .st_done(z_st_done),
    .st_result(z_st_result), .busy(z_busy));

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa * 2;
      if (aa >= 256) aa = aa ^ 'h11B;
    end
    return acc[7:0];
  endfunction

  // S-box from definition: brute-force multiplicative inverse, then affine map
  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input int nbytes);
    logic [127:0] r = '0;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = sbox_tab[d[8*i +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic model_reset();
    m_key = '0; m_st = '0; m_last_st = 1'b1;
  endtask

  // Ticks until the chosen done pulse; ok=0 if the bound expires
  task automatic wait_done(input bit is_key, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (is_key ? key_done : st_done) begin ok = 1'b1; at = cyc; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #1;
    checks++;
    if ({key_grant, key_done, st_grant, st_done, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 00000", {key_grant, key_done, st_grant, st_done, busy});
    end
    checks++;
    if (key_result !== 32'h0 || st_result !== 128'h0) begin
      errors++; $display("FAIL reset_results: got %h %h want 0", key_result, st_result);
    end
    tick(); tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_key_single();
    int at; bit ok;
    cyc = 0; key_word = 32'h01FF5300; key_req = 1'b1;
    tick();
    key_req = 1'b0;
    checks++;
    if ({key_grant, st_grant, busy} !== 3'b101) begin
      errors++; $display("FAIL key_grant_c1: got kg/sg/busy=%b want 101", {key_grant, st_grant, busy});
    end
    wait_done(1'b1, at, ok);
    checks++;
    if (!ok || at != 6) begin errors++; $display("FAIL key_done_cycle: got %0d want 6", at); end
    checks++;
    if (key_result !== 32'h7C16ED63) begin
      errors++; $display("FAIL key_result: got %h want 7c16ed63", key_result);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b want 0", busy); end
    m_key = 32'h7C16ED63; m_last_st = 1'b0;
  endtask

  task automatic test_st_single();
    int at; bit ok;
    cyc = 0; st_data = '0; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    checks++;
    if ({key_grant, st_grant} !== 2'b01) begin
      errors++; $display("FAIL st_grant_c1: got kg/sg=%b want 01", {key_grant, st_grant});
    end
    wait_done(1'b0, at, ok);
    checks++;
    if (!ok || at != 18) begin errors++; $display("FAIL st_done_cycle: got %0d want 18", at); end
    checks++;
    if (st_result !== {16{8'h63}}) begin errors++; $display("FAIL st_result_zero: got %h want 63..63", st_result); end
    checks++;
    if (key_result !== m_key) begin errors++; $display("FAIL key_kept: got %h want %h", key_result, m_key); end
    m_st = {16{8'h63}}; m_last_st = 1'b1;
  endtask

  task automatic test_tie_rr();
    int at; bit ok;
    logic [31:0] w1, w2;
    test_reset();
    w1 = $urandom; w2 = $urandom; st_data = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0; key_word = w1; key_req = 1'b1; st_req = 1'b1;
    tick();
    key_req = 1'b0;
    checks++;
    if ({key_grant, st_grant} !== 2'b10) begin errors++; $display("FAIL tie1_winner: got kg/sg=%b want 10", {key_grant, st_grant}); end
    wait_done(1'b1, at, ok);
    checks++;
    if (!ok || at != 6) begin errors++; $display("FAIL tie1_key_done: got %0d want 6", at); end
    checks++;
    if (key_result !== ref_sub({96'b0, w1}, 4)) begin
      errors++; $display("FAIL tie1_key_result: got %h want %h", key_result, ref_sub({96'b0, w1}, 4));
    end
    // second tie in the done cycle: KEY was served last, so ST wins
    key_word = w2; key_req = 1'b1;
    tick();
    st_req = 1'b0;
    checks++;
    if (cyc != 7 || {key_grant, st_grant} !== 2'b01) begin
      errors++; $display("FAIL tie2_winner: got kg/sg=%b at %0d want 01 at 7", {key_grant, st_grant}, cyc);
    end
    wait_done(1'b0, at, ok);
    checks++;
    if (!ok || at != 24) begin errors++; $display("FAIL tie2_st_done: got %0d want 24", at); end
    checks++;
    if (st_result !== ref_sub(st_data, 16)) begin
      errors++; $display("FAIL tie2_st_result: got %h want %h", st_result, ref_sub(st_data, 16));
    end
    tick();
    key_req = 1'b0;
    checks++;
    if (key_grant !== 1'b1) begin errors++; $display("FAIL pending_key_grant: got %b want 1", key_grant); end
    wait_done(1'b1, at, ok);
    checks++;
    if (!ok || key_result !== ref_sub({96'b0, w2}, 4)) begin
      errors++; $display("FAIL pending_key_result: got %h want %h", key_result, ref_sub({96'b0, w2}, 4));
    end
    m_key = key_result; m_st = ref_sub(st_data, 16); m_last_st = 1'b0;
  endtask

  task automatic test_fixed_priority();
    bit seen;
    test_reset();
    z_key_req = 1'b1; z_st_req = 1'b1;
    tick();
    z_key_req = 1'b0;
    checks++;
    if ({z_key_grant, z_st_grant} !== 2'b10) begin errors++; $display("FAIL fixed_tie1: got kg/sg=%b want 10", {z_key_grant, z_st_grant}); end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin tick(); seen = z_key_done; end
    checks++;
    if (!seen) begin errors++; $display("FAIL fixed_done1: got timeout want key_done"); end
    z_key_req = 1'b1;
    tick();
    z_key_req = 1'b0;
    checks++;
    if ({z_key_grant, z_st_grant} !== 2'b10) begin errors++; $display("FAIL fixed_tie2: got kg/sg=%b want 10", {z_key_grant, z_st_grant}); end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin tick(); seen = z_key_done; end
    tick();
    z_st_req = 1'b0;
    checks++;
    if (!seen || z_st_grant !== 1'b1) begin errors++; $display("FAIL fixed_st_later: got %b want 1", z_st_grant); end
    for (int n = 0; n < 20; n++) tick();
  endtask

  task automatic test_ignore_while_busy();
    int at; bit ok; bit early;
    logic [31:0] w;
    w = $urandom; st_data = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    early = 1'b0;
    while (cyc < 5) begin tick(); early |= key_grant; end
    key_word = w; key_req = 1'b1;
    tick(); early |= key_grant;
    key_req = 1'b0;
    while (cyc < 8) begin tick(); early |= key_grant; end
    key_req = 1'b1;
    ok = 1'b0; at = -1;
    for (int n = 0; n < 40 && !ok; n++) begin
      tick(); early |= key_grant;
      if (st_done) begin ok = 1'b1; at = cyc; end
    end
    checks++;
    if (early) begin errors++; $display("FAIL key_ignored_in_run: got grant want none"); end
    checks++;
    if (!ok || at != 18) begin errors++; $display("FAIL ignore_st_done: got %0d want 18", at); end
    tick();
    key_req = 1'b0;
    checks++;
    if (key_grant !== 1'b1) begin errors++; $display("FAIL held_key_grant_c19: got %b want 1", key_grant); end
    wait_done(1'b1, at, ok);
    checks++;
    if (!ok || key_result !== ref_sub({96'b0, w}, 4) || st_result !== ref_sub(st_data, 16)) begin
      errors++; $display("FAIL ignore_results: got %h %h want %h %h", key_result, st_result,
                         ref_sub({96'b0, w}, 4), ref_sub(st_data, 16));
    end
    m_key = key_result; m_st = st_result; m_last_st = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int at; bit ok; bit spur;
    st_data = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    while (cyc < 8) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({key_grant, key_done, st_grant, st_done, busy} !== 5'b0 || key_result !== 32'h0 || st_result !== 128'h0) begin
      errors++; $display("FAIL async_reset: got busy=%b key=%h st=%h want all 0", busy, key_result, st_result);
    end
    tick();
    reset = 1'b0;
    model_reset();
    spur = 1'b0;
    for (int n = 0; n < 25; n++) begin tick(); spur |= st_done | busy; end
    checks++;
    if (spur) begin errors++; $display("FAIL abandoned_run: got done/busy after reset want none"); end
    st_data = {$urandom, $urandom, $urandom, $urandom};
    st_data[7:0] = 8'h53;
    cyc = 0; st_req = 1'b1;
    tick();
    st_req = 1'b0;
    wait_done(1'b0, at, ok);
    checks++;
    if (!ok || st_result[7:0] !== 8'hED) begin errors++; $display("FAIL reissue_byte0: got %h want ed", st_result[7:0]); end
    checks++;
    if (st_result !== ref_sub(st_data, 16) || key_result !== 32'h0) begin
      errors++; $display("FAIL reissue_full: got %h want %h", st_result, ref_sub(st_data, 16));
    end
    m_st = st_result; m_last_st = 1'b1;
  endtask

  // Random single/tie requests checked against the arbitration and latency rules
  task automatic test_random();
    int at, choice, nserve; bit ok, own_key, second_key;
    logic [31:0] w;
    for (int it = 0; it < 12; it++) begin
      choice = $urandom_range(0, 2);
      w = $urandom; st_data = {$urandom, $urandom, $urandom, $urandom};
      key_word = w;
      key_req = (choice != 1); st_req = (choice != 0);
      if (choice == 2) own_key = m_last_st; else own_key = (choice == 0);
      second_key = !own_key;
      nserve = (choice == 2) ? 2 : 1;
      for (int s = 0; s < nserve; s++) begin
        if (s == 1) own_key = second_key;
        cyc = 0;
        tick();
        if (own_key) key_req = 1'b0; else st_req = 1'b0;
        checks++;
        if ({key_grant, st_grant} !== {own_key, !own_key}) begin
          errors++; $display("FAIL rnd%0d_grant: got kg/sg=%b want %b", it, {key_grant, st_grant}, {own_key, !own_key});
        end
        wait_done(own_key, at, ok);
        if (own_key) m_key = ref_sub({96'b0, w}, 4)[31:0];
        else         m_st  = ref_sub(st_data, 16);
        m_last_st = !own_key;
        checks++;
        if (!ok || at != (own_key ? 6 : 18)) begin
          errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, at, own_key ? 6 : 18);
        end
        checks++;
        if (key_result !== m_key || st_result !== m_st) begin
          errors++; $display("FAIL rnd%0d_results: got %h %h want %h %h", it, key_result, st_result, m_key, m_st);
        end
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
  endtask

  initial begin
    build_sbox();
    model_reset();
    test_reset();
    test_key_single();
    test_st_single();
    test_tie_rr();
    test_fixed_priority();
    test_ignore_while_busy();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
